// File: rtl/rib_arb_pkg.sv
// Shared types and helpers for the RIB bus arbiter.
package rib_arb_pkg;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} rib_arb_state_e;

  localparam int RIB_ARB_MAX_MASTERS = 8;

  function automatic int rib_arb_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rib_arb_pick.sv
// Combinational winner picker: first masked requester found searching upward from start, wrapping.
module rib_arb_pick
  import rib_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = rib_arb_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] idx,
  output logic           vld
);

  always_comb begin
    int i;
    i   = 0;
    win = '0;
    idx = '0;
    vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      i = int'(start) + k;
      if (i >= N) i = i - N;
      if (!vld && req[i] && mask[i]) begin
        win[i] = 1'b1;
        idx    = IDW'(i);
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// Registered multi-master RIB arbiter with lock and starvation timeout.
// Define RIB_ARB_RR_EN for round-robin picking; otherwise fixed priority (index 0 highest).
module rib_arbiter
  import rib_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 16,
  localparam int IDW        = rib_arb_idw(NUM_MASTERS)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [NUM_MASTERS-1:0] lock_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDW-1:0]         gnt_id_o,
  output logic                   gnt_valid_o,
  output logic [NUM_MASTERS-1:0] hold_o,
  output logic                   preempt_o
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  rib_arb_state_e         state;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [NUM_MASTERS-1:0] pick_mask, pick_win, nxt_gnt;
  logic [IDW-1:0]         pick_idx, pick_start, nxt_id;
  logic                   pick_vld, nxt_vld;
  logic                   own_req, own_lock, others, timeout, force_rel, use_pick;

  assign hold_o = req_i & ~gnt_o;

  always_comb begin
    own_req   = |(req_i & gnt_o);
    own_lock  = |(lock_i & gnt_o);
    others    = |(req_i & ~gnt_o);
    timeout   = (MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD)) && others;
    force_rel = (state == OWNED) && own_req && own_lock && timeout;
    // Only a forced release excludes the owner; a voluntary re-arbitration may re-pick it.
    pick_mask = force_rel ? ~gnt_o : '1;
    use_pick  = 1'b1;
    if (state == OWNED && own_req && own_lock && !timeout) use_pick = 1'b0;
    nxt_gnt = use_pick ? pick_win : gnt_o;
    nxt_id  = use_pick ? pick_idx : gnt_id_o;
    nxt_vld = use_pick ? pick_vld : 1'b1;
    if (!nxt_vld || nxt_gnt != gnt_o || !others) cnt_nxt = '0;
    else if (cnt != CW'(MAX_HOLD))               cnt_nxt = cnt + CW'(1);
    else                                         cnt_nxt = cnt;
  end

`ifdef RIB_ARB_RR_EN
  logic [IDW-1:0] ptr;

  assign pick_start = ptr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                 ptr <= '0;
    else if (use_pick && pick_vld)
      ptr <= (pick_idx == IDW'(NUM_MASTERS - 1)) ? '0 : pick_idx + IDW'(1);
  end
`else
  assign pick_start = '0;
`endif

  rib_arb_pick #(.N(NUM_MASTERS), .IDW(IDW)) u_pick (
    .req   (req_i),
    .mask  (pick_mask),
    .start (pick_start),
    .win   (pick_win),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      gnt_o       <= '0;
      gnt_id_o    <= '0;
      gnt_valid_o <= 1'b0;
      preempt_o   <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= nxt_vld ? OWNED : IDLE;
      gnt_o       <= nxt_vld ? nxt_gnt : '0;
      gnt_id_o    <= nxt_vld ? nxt_id : '0;
      gnt_valid_o <= nxt_vld;
      preempt_o   <= force_rel;
      cnt         <= cnt_nxt;
    end
  end

endmodule
